run_mode_decoder: RTL and testbench

Decoder-side counterpart of the encoder's mode determination. Per pixel request, it classifies the context (a,b,c,d) as regular or run without knowledge of x. In run mode it consumes run-length bits from the bit unpacker, reconstructs the run pixels (value Ra), and signals run interruption or end-of-line. It sits between the bit unpacker and the pixel reconstruction and line-buffer logic.

---
 rtl/run_mode_decoder_pkg.sv | 37 +++
 rtl/run_mode_decoder_classifier.sv | 36 +++
 rtl/run_mode_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_run_mode_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_mode_decoder_pkg.sv
// Shared definitions for the run-mode decoder: mode codes, FSM encodings,
// RUNindex width and the J (run-length order) table.
package run_mode_decoder_pkg;

  localparam int RI_W       = 5;
  localparam int LINE_W_DEF = 16;

  localparam logic [1:0] MODE_REGULAR       = 2'd0;
  localparam logic [1:0] MODE_RUN           = 2'd1;
  localparam logic [1:0] MODE_RUN_INTERRUPT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLAG  = 2'd1,
    ST_COUNT = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // Where the FSM goes once the pending run pixels have all been accepted.
  typedef enum logic [1:0] {
    NXT_FLAG = 2'd0,
    NXT_EOL  = 2'd1,
    NXT_INT  = 2'd2
  } emit_next_e;

  localparam logic [3:0] J_TABLE [0:31] = '{
    4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
    4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
    4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  function automatic logic [3:0] j_of(input logic [RI_W-1:0] idx);
    j_of = J_TABLE[idx];
  endfunction

endpackage

// File: rtl/run_mode_decoder_classifier.sv
// Combinational context test: the pixel is coded in run mode when all three
// local gradients are within NEAR.
module run_context_classifier
  import run_mode_decoder_pkg::*;
#(
  parameter int pixel_length = 8,
  parameter int NEAR         = 0
) (
  input  logic [pixel_length-1:0] a,
  input  logic [pixel_length-1:0] b,
  input  logic [pixel_length-1:0] c,
  input  logic [pixel_length-1:0] d,
  output logic                    is_run
);

  localparam logic [pixel_length:0] NEAR_V = NEAR[pixel_length:0];

  // Magnitude of x-y, formed as a signed difference one bit wider than a sample.
  function automatic logic [pixel_length:0] abs_diff(
    input logic [pixel_length-1:0] x,
    input logic [pixel_length-1:0] y
  );
    logic signed [pixel_length:0] df;
    df = $signed({1'b0, x}) - $signed({1'b0, y});
    if (df[pixel_length]) begin
      abs_diff = -df;
    end else begin
      abs_diff = df;
    end
  endfunction

  assign is_run = (abs_diff(d, b) <= NEAR_V) &&
                  (abs_diff(b, c) <= NEAR_V) &&
                  (abs_diff(c, a) <= NEAR_V);

endmodule

// File: rtl/run_mode_decoder.sv
// Decoder-side run-mode handling: classifies each pixel request, consumes the
// run-length bits and replays the run pixel (Ra) until interruption or end of line.
module run_mode_decoder
  import run_mode_decoder_pkg::*;
#(
  parameter int pixel_length = 8,
  parameter int mode_length  = 2,
  parameter int LINE_W       = LINE_W_DEF,
  parameter int NEAR         = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sos,
  input  logic                    start_dec,
  input  logic [pixel_length-1:0] a,
  input  logic [pixel_length-1:0] b,
  input  logic [pixel_length-1:0] c,
  input  logic [pixel_length-1:0] d,
  input  logic [LINE_W-1:0]       line_remaining,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [pixel_length-1:0] pix_out,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [mode_length-1:0]  mode,
  output logic                    mode_valid,
  output logic [RI_W-1:0]         run_index,
  output logic                    busy
);

  localparam logic [LINE_W-1:0] CNT_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
  localparam logic [RI_W-1:0]   RI_MAX  = {RI_W{1'b1}};
  localparam logic [RI_W-1:0]   RI_ZERO = {RI_W{1'b0}};

  state_e                  state_q, state_d;
  emit_next_e              next_q, next_d;
  logic [pixel_length-1:0] ra_q, ra_d;
  logic [LINE_W-1:0]       rem_q, rem_d;
  logic [LINE_W-1:0]       cnt_q, cnt_d;
  logic [3:0]              nbits_q, nbits_d;
  logic [RI_W-1:0]         run_index_q, run_index_d;
  logic [mode_length-1:0]  mode_q, mode_d;
  logic                    mode_valid_q, mode_valid_d;

  logic                    is_run_s;
  logic [3:0]              j_s;
  logic [LINE_W-1:0]       rg_s;
  logic                    bit_take_s;
  logic [LINE_W-1:0]       shift_s;
  logic [LINE_W-1:0]       cnt_fin_s;
  logic [RI_W-1:0]         ri_inc_s;
  logic [RI_W-1:0]         ri_dec_s;
  logic [RI_W-1:0]         ri_hold_s;

  run_context_classifier #(
    .pixel_length(pixel_length),
    .NEAR        (NEAR)
  ) u_classifier (
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .is_run(is_run_s)
  );

  assign j_s        = j_of(run_index_q);
  assign rg_s       = CNT_ONE << j_s;
  assign bit_take_s = bit_valid && bit_ready;
  assign shift_s    = {cnt_q[LINE_W-2:0], bit_in};
  // A count reaching the end of line is a stream error; keep the interruption pixel on the line.
  assign cnt_fin_s  = (shift_s >= rem_q) ? (rem_q - CNT_ONE) : shift_s;
  assign ri_inc_s   = (run_index_q == RI_MAX)  ? run_index_q : (run_index_q + 5'd1);
  assign ri_dec_s   = (run_index_q == RI_ZERO) ? run_index_q : (run_index_q - 5'd1);
  // The interrupt pulse shows the pre-decrement index; the decrement lands at the end of that cycle.
  assign ri_hold_s  = (mode_valid_q && (mode_q == mode_length'(MODE_RUN_INTERRUPT))) ? ri_dec_s
                                                                                      : run_index_q;

  // Next-state, counter and mode-report logic of the run FSM.
  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    ra_d         = ra_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    nbits_d      = nbits_q;
    run_index_d  = ri_hold_s;
    mode_d       = mode_q;
    mode_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        run_index_d = sos ? RI_ZERO : ri_hold_s;
        if (start_dec && is_run_s) begin
          ra_d    = a;
          rem_d   = line_remaining;
          state_d = ST_FLAG;
        end else if (start_dec) begin
          mode_d       = mode_length'(MODE_REGULAR);
          mode_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FLAG: begin
        if (bit_take_s && bit_in) begin
          run_index_d = (rem_q >= rg_s) ? ri_inc_s : run_index_q;
          state_d     = ST_EMIT;
          if (rem_q > rg_s) begin
            cnt_d  = rg_s;
            rem_d  = rem_q - rg_s;
            next_d = NXT_FLAG;
          end else begin
            cnt_d  = rem_q;
            next_d = NXT_EOL;
          end
        end else if (bit_take_s && (j_s == 4'd0)) begin
          state_d      = ST_IDLE;
          mode_d       = mode_length'(MODE_RUN_INTERRUPT);
          mode_valid_d = 1'b1;
        end else if (bit_take_s) begin
          cnt_d   = {LINE_W{1'b0}};
          nbits_d = j_s;
          state_d = ST_COUNT;
        end else begin
          state_d = ST_FLAG;
        end
      end

      ST_COUNT: begin
        if (bit_take_s && (nbits_q == 4'd1)) begin
          if (cnt_fin_s == {LINE_W{1'b0}}) begin
            state_d      = ST_IDLE;
            mode_d       = mode_length'(MODE_RUN_INTERRUPT);
            mode_valid_d = 1'b1;
          end else begin
            cnt_d   = cnt_fin_s;
            next_d  = NXT_INT;
            state_d = ST_EMIT;
          end
        end else if (bit_take_s) begin
          cnt_d   = shift_s;
          nbits_d = nbits_q - 4'd1;
        end else begin
          state_d = ST_COUNT;
        end
      end

      ST_EMIT: begin
        if (pix_ready && (cnt_q == CNT_ONE)) begin
          case (next_q)
            NXT_FLAG: begin
              state_d = ST_FLAG;
            end
            NXT_EOL: begin
              state_d      = ST_IDLE;
              mode_d       = mode_length'(MODE_RUN);
              mode_valid_d = 1'b1;
            end
            default: begin
              state_d      = ST_IDLE;
              mode_d       = mode_length'(MODE_RUN_INTERRUPT);
              mode_valid_d = 1'b1;
            end
          endcase
        end else if (pix_ready) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_EMIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      next_q       <= NXT_FLAG;
      ra_q         <= {pixel_length{1'b0}};
      rem_q        <= {LINE_W{1'b0}};
      cnt_q        <= {LINE_W{1'b0}};
      nbits_q      <= 4'd0;
      run_index_q  <= RI_ZERO;
      mode_q       <= {mode_length{1'b0}};
      mode_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      ra_q         <= ra_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      nbits_q      <= nbits_d;
      run_index_q  <= run_index_d;
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
    end
  end

  assign bit_ready  = (state_q == ST_FLAG) || (state_q == ST_COUNT);
  assign pix_valid  = (state_q == ST_EMIT);
  assign pix_out    = ra_q;
  assign mode       = mode_q;
  assign mode_valid = mode_valid_q;
  assign run_index  = run_index_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_run_mode_decoder.sv
// Self-checking bench for run_mode_decoder: directed scenarios plus randomized
// requests compared against a transaction-level model of run decoding.
module tb_run_mode_decoder;

  localparam int PL = 8;
  localparam int ML = 2;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sos;
  logic          start_dec;
  logic [PL-1:0] a, b, c, d;
  logic [LW-1:0] line_remaining;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [PL-1:0] pix_out;
  logic          pix_valid;
  logic          pix_ready;
  logic [ML-1:0] mode;
  logic          mode_valid;
  logic [4:0]    run_index;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int jt[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};
  bit bq[128];
  int ri_m = 0;
  int stall_at = 0;

  always #5 clk = ~clk;

  run_mode_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .sos           (sos),
    .start_dec     (start_dec),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .line_remaining(line_remaining),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .pix_out       (pix_out),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .mode          (mode),
    .mode_valid    (mode_valid),
    .run_index     (run_index),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ctx_is_run(input int a_, input int b_, input int c_, input int d_);
    int g1, g2, g3;
    g1 = d_ - b_; if (g1 < 0) g1 = -g1;
    g2 = b_ - c_; if (g2 < 0) g2 = -g2;
    g3 = c_ - a_; if (g3 < 0) g3 = -g3;
    return (g1 <= 0) && (g2 <= 0) && (g3 <= 0);
  endfunction

  // Walks the run-length bits in bq from index 0, starting at run index ri_m.
  function automatic void model_run(input int rem0, output int npix, output int nbits,
                                    output int md, output int ri_p, output int ri_f);
    int rem, ri, k, rg, v;
    rem = rem0; ri = ri_m; k = 0; npix = 0; md = 0; ri_p = 0; ri_f = 0;
    while (k < 120) begin
      if (bq[k]) begin
        k++;
        rg = 1 << jt[ri];
        if (rem > rg) begin
          npix += rg;
          rem -= rg;
          ri = (ri < 31) ? ri + 1 : 31;
        end else begin
          npix += rem;
          if (rem == rg) ri = (ri < 31) ? ri + 1 : 31;
          md = 1; ri_p = ri; ri_f = ri;
          break;
        end
      end else begin
        k++;
        v = 0;
        for (int i = 0; i < jt[ri]; i++) begin
          v = v * 2 + int'(bq[k]);
          k++;
        end
        if (v >= rem) v = rem - 1;
        npix += v;
        md = 2; ri_p = ri; ri_f = (ri > 0) ? ri - 1 : 0;
        break;
      end
    end
    nbits = k;
  endfunction

  task automatic idle_inputs();
    sos = 1'b0; start_dec = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; pix_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    ri_m = 0;
  endtask

  task automatic fill_bits(input int p1);
    for (int i = 0; i < 128; i++) bq[i] = ($urandom_range(0, 99) < p1);
  endtask

  task automatic reg_req(input int a_, input int b_, input int c_, input int d_, input bit sos_v);
    @(negedge clk);
    a = 8'(a_); b = 8'(b_); c = 8'(c_); d = 8'(d_);
    sos = sos_v; start_dec = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; pix_ready = 1'b1;
    if (sos_v) ri_m = 0;
    @(negedge clk);
    start_dec = 1'b0; sos = 1'b0; bit_valid = 1'b0;
    chk("reg_mv", mode_valid, 1);
    chk("reg_mode", mode, 0);
    chk("reg_busy", busy, 0);
    chk("reg_bit_ready", bit_ready, 0);
    chk("reg_pix_valid", pix_valid, 0);
    chk("reg_ri", run_index, ri_m);
    @(negedge clk);
    chk("reg_mv_once", mode_valid, 0);
  endtask

  // rmode: 0 random handshakes, 1 always ready, 2 always ready except a 3-cycle pix_ready stall
  task automatic run_req(input int a_, input int b_, input int c_, input int d_,
                         input int rem, input bit sos_v, input int rmode);
    int np, nb, md, rip, rif;
    int k, got_np, cyc, stall_left;
    bit done;
    logic [1:0] gmd;
    logic [4:0] gri;
    if (sos_v) ri_m = 0;
    model_run(rem, np, nb, md, rip, rif);
    @(negedge clk);
    a = 8'(a_); b = 8'(b_); c = 8'(c_); d = 8'(d_);
    line_remaining = 16'(rem);
    sos = sos_v; start_dec = 1'b1; bit_valid = 1'b0; pix_ready = 1'b0;
    k = 0; got_np = 0; cyc = 0; stall_left = 0; done = 1'b0; gmd = 2'd0; gri = 5'd0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode_valid) begin
        done = 1'b1; gmd = mode; gri = run_index;
      end
      if (busy) begin
        start_dec = 1'($urandom_range(0, 1));
        sos = 1'($urandom_range(0, 1));
        a = 8'($urandom);
      end else begin
        start_dec = 1'b0; sos = 1'b0;
      end
      bit_valid = (rmode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bit_in = (k < 128) ? bq[k] : 1'b0;
      if (rmode == 0) pix_ready = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0) begin pix_ready = 1'b0; stall_left--; end
      else pix_ready = 1'b1;
      if (bit_valid && bit_ready) k++;
      if (pix_valid) begin
        chk("pix_out", pix_out, a_);
        chk("bit_ready_in_emit", bit_ready, 0);
        if (pix_ready) begin
          got_np++;
          if (rmode == 2 && got_np == stall_at) stall_left = 3;
        end
      end
    end
    idle_inputs();
    if (!done) begin
      chk("timeout", 0, 1);
      do_reset();
    end else begin
      chk("npix", got_np, np);
      chk("nbits", k, nb);
      chk("mode", gmd, md);
      chk("ri_pulse", gri, rip);
      @(negedge clk);
      chk("mv_once", mode_valid, 0);
      chk("ri_final", run_index, rif);
      ri_m = rif;
    end
  endtask

  task automatic req(input int a_, input int b_, input int c_, input int d_,
                     input int rem, input bit sos_v, input int rmode);
    if (ctx_is_run(a_, b_, c_, d_)) run_req(a_, b_, c_, d_, rem, sos_v, rmode);
    else reg_req(a_, b_, c_, d_, sos_v);
  endtask

  initial begin
    int v, rem;
    bit sv;
    reset = 1'b0;
    idle_inputs();
    a = '0; b = '0; c = '0; d = '0; line_remaining = 16'd1;
    repeat (3) @(negedge clk);
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_mode_valid", mode_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_mode", mode, 0);
    chk("rst_run_index", run_index, 0);
    reset = 1'b1;

    // regular contexts, including gradients of exactly one
    reg_req(10, 12, 12, 12, 1'b0);
    reg_req(50, 50, 50, 51, 1'b0);
    reg_req(51, 50, 50, 50, 1'b0);

    // short interrupt: 2 pixels, interrupt at index 2, then index 1
    fill_bits(50); bq[0] = 1'b1; bq[1] = 1'b1; bq[2] = 1'b0;
    run_req(50, 50, 50, 50, 10, 1'b0, 1);

    // end of line after three flag bits
    do_reset();
    fill_bits(50); bq[0] = 1'b1; bq[1] = 1'b1; bq[2] = 1'b1;
    run_req(50, 50, 50, 50, 3, 1'b0, 1);

    // J>0 path with a pixel stall inside a two-pixel segment
    do_reset();
    fill_bits(50);
    bq[0] = 1'b1; bq[1] = 1'b1; bq[2] = 1'b1; bq[3] = 1'b1; bq[4] = 1'b1; bq[5] = 1'b0; bq[6] = 1'b1;
    stall_at = 5;
    run_req(50, 50, 50, 50, 100, 1'b0, 2);

    // reset while pixels are pending
    do_reset();
    @(negedge clk);
    a = 8'd77; b = 8'd77; c = 8'd77; d = 8'd77; line_remaining = 16'd50;
    start_dec = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; pix_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start_dec = 1'b0;
      if (pix_valid) break;
    end
    chk("rst_emit_reached", pix_valid, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bit_valid = 1'b0;
    chk("rst_mid_pix_valid", pix_valid, 0);
    chk("rst_mid_bit_ready", bit_ready, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_run_index", run_index, 0);
    chk("rst_mid_pix_out", pix_out, 0);
    ri_m = 0;
    reg_req(10, 12, 12, 12, 1'b0);

    // randomized requests with random handshakes
    for (int it = 0; it < 80; it++) begin
      fill_bits(70);
      sv = ($urandom_range(0, 7) == 0);
      rem = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 120);
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, 255);
        req(v, v, v, v, rem, sv, 0);
      end else begin
        req($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), rem, sv, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
